multiplier_using_rca: RTL and testbench
=======================================

# multiplier_using_rca

Unsigned 8×8 array multiplier producing a 16-bit product. Partial products are summed through a chain of structural ripple-carry adder (RCA) rows built from full adders, with a registered output. It serves as the datapath reference multiplier in the arithmetic blocks and as a timing baseline for faster adder variants.

## Interface
- No parameters. Widths are fixed at 8×8→16.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- A  input  8  multiplicand, unsigned.
- B  input  8  multiplier, unsigned.
- P  output  16  product A×B, unsigned, registered.

## Operation
- Partial products: pp[i][j] = A[j] & B[i], for i,j in 0..7.
- Row 0 is pp[0]. P[0] = pp[0][0].
- Rows 1..7: each row is one 8-bit RCA of 8 full adders, carry rippling LSB→MSB with carry-in 0.
  - Operand X = pp[i].
  - Operand Y = {carry-out of previous row, previous row sum[7:1]}.
  - Row i emits sum bit 0 as P[i].
- After row 7: P[14:7] = row-7 sum[7:0] and P[15] = row-7 carry-out.
- The adder array is built only from a full-adder cell (sum = a^b^c, cout = ab|ac|bc). The `*` operator is not used.
- Result is exact for all 65536 input pairs. Overflow is impossible: max 255×255 = 65025.
- No handshake. A new operand pair is accepted every cycle (throughput 1/cycle).

## Timing
- Reset: while rst_n = 0, P = 16'h0000 immediately (asynchronous) and all pipeline registers clear. Release is synchronous to the next rising clk edge.
- Default build: A/B are sampled combinationally through the array. P updates on the rising clk edge after the operands are applied. Latency is 1 cycle.
- A and B must be stable for the full array delay before the capturing edge: 7 rows × 8-bit ripple, critical path ~ 7 + 8 FA delays.
- Reset asserted mid-stream: all in-flight results are discarded. The first valid P appears 1 cycle after the first post-reset edge (2 with the pipeline stage).
- Operands changing every cycle: each P reflects exactly the pair sampled at its capturing edge, with no mixing between pairs.

## Configuration
- MUL_PIPE_STAGE_EN
  - Defined:
    - A register stage is inserted after RCA row 3. It captures:
      - row-3 sum and carry-out;
      - P[3:0];
      - A;
      - B[7:4].
    - Rows 4..7 operate on the registered values.
    - Latency is 2 cycles, throughput is still 1/cycle, and the critical path is roughly halved.
    - All stage registers reset to 0 asynchronously on rst_n low.
  - Not defined: purely combinational array plus the output register, latency 1.
  - Numerical results are identical in both builds.

## Test plan
- Reset: assert rst_n = 0 with A = 255, B = 255 → P = 0 immediately and it stays 0 until rst_n is released and the next edge occurs.
- Directed sequence, one pair per cycle, each P checked at the required latency:
  - 10×10 → 100
  - 100×200 → 20000
  - 120×100 → 12000
  - 50×200 → 10000
  - 80×20 → 1600
  - 40×60 → 2400
- Corners:
  - 0×255 → 0
  - 255×0 → 0
  - 1×1 → 1
  - 255×255 → 65025 (exercises P[15] and the full carry chain)
  - 128×2 → 256
- Back-to-back changing operands (255×255 then 1×1 then 0×0 on consecutive cycles) → P sequence 65025, 1, 0 with no stale or blended values.
- Reset mid-stream: drop rst_n for less than 1 cycle between two operand pairs → P = 0 asynchronously, then the next sampled pair is correct at the normal latency.
- Random: 10000 random A/B pairs compared against a reference A×B, run in both builds (MUL_PIPE_STAGE_EN defined and undefined) → zero mismatches.

Source files
------------

// File: rtl/multiplier_using_rca.sv
// Unsigned 8x8 array multiplier: partial-product rows summed by ripple-carry adder rows, registered 16-bit product.
// Define MUL_PIPE_STAGE_EN to register the array after row 3 (latency 2 instead of 1).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);
endmodule

module rca8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  // Each bit keeps its own carry net so the chain is a plain ripple, not a self-referencing vector.
  for (genvar k = 0; k < 8; k++) begin : g_bit
    logic c_in;
    logic c_out;
    if (k == 0) begin : g_lsb
      assign c_in = cin;
    end else begin : g_mid
      assign c_in = g_bit[k-1].c_out;
    end
    full_adder u_fa (
      .a    (a[k]),
      .b    (b[k]),
      .c    (c_in),
      .sum  (sum[k]),
      .cout (c_out)
    );
  end
  assign cout = g_bit[7].c_out;
endmodule

module multiplier_using_rca (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P
);
  logic [7:0]  pp0;
  logic [7:0]  a_st;
  logic [3:0]  b_st;
  logic [7:0]  s3_st;
  logic        c3_st;
  logic [3:0]  p_lo;
  logic [3:0]  p_lo_st;
  logic [15:0] p_next;

  assign pp0 = A & {8{B[0]}};

  // Rows 4..7 read the (optionally registered) upper half of the operands and row-3 result.
  for (genvar i = 1; i < 8; i++) begin : g_row
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] sum;
    logic       cout;
    if (i < 4) begin : g_front
      assign x = A & {8{B[i]}};
    end else begin : g_back
      assign x = a_st & {8{b_st[i-4]}};
    end
    if (i == 1) begin : g_first
      assign y = {1'b0, pp0[7:1]};
    end else if (i == 4) begin : g_stage
      assign y = {c3_st, s3_st[7:1]};
    end else begin : g_chain
      assign y = {g_row[i-1].cout, g_row[i-1].sum[7:1]};
    end
    rca8 u_rca (
      .a    (x),
      .b    (y),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
    );
  end

  assign p_lo = {g_row[3].sum[0], g_row[2].sum[0], g_row[1].sum[0], pp0[0]};

`ifdef MUL_PIPE_STAGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_st    <= '0;
      b_st    <= '0;
      s3_st   <= '0;
      c3_st   <= 1'b0;
      p_lo_st <= '0;
    end else begin
      a_st    <= A;
      b_st    <= B[7:4];
      s3_st   <= g_row[3].sum;
      c3_st   <= g_row[3].cout;
      p_lo_st <= p_lo;
    end
  end
`else
  assign a_st    = A;
  assign b_st    = B[7:4];
  assign s3_st   = g_row[3].sum;
  assign c3_st   = g_row[3].cout;
  assign p_lo_st = p_lo;
`endif

  assign p_next = {g_row[7].cout, g_row[7].sum,
                   g_row[6].sum[0], g_row[5].sum[0], g_row[4].sum[0], p_lo_st};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) P <= '0;
    else        P <= p_next;
  end
endmodule

// File: tb/tb_multiplier_using_rca.sv
// Self-checking bench for multiplier_using_rca; latency follows MUL_PIPE_STAGE_EN.
module tb_multiplier_using_rca;
`ifdef MUL_PIPE_STAGE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [15:0] P;

  typedef struct {
    int          due;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  edge_cnt = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  multiplier_using_rca dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .P     (P)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = '0;
    for (int k = 0; k < 8; k++)
      if (b[k]) acc = acc + ({8'h00, a} << k);
    return acc;
  endfunction

  // Drive one pair, advance one edge, report the scoreboard entry that is due now (if any).
  task automatic step(input logic [7:0] a, input logic [7:0] b, input bit push,
                      output bit got, output logic [15:0] obs, output logic [15:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    if (push) sb_q.push_back('{due: edge_cnt + LAT, exp: ref_mul(a, b)});
    @(posedge clk);
    edge_cnt++;
    #1;
    got = 1'b0;
    obs = P;
    exp = '0;
    if (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
      got = 1'b1;
      exp = sb_q[0].exp;
      void'(sb_q.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    A = 8'hFF;
    B = 8'hFF;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (P !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async: P=%0h expected 0", P);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (P !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: P=%0h expected 0", k, P);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_list(input string name, input logic [7:0] av[], input logic [7:0] bv[]);
    bit got;
    logic [15:0] obs, exp;
    int guard;
    for (int k = 0; k < av.size(); k++) begin
      step(av[k], bv[k], 1'b1, got, obs, exp);
      if (got) begin
        n_tests++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL %s: P=%0d expected %0d", name, obs, exp);
        end
      end
    end
    guard = 0;
    while (sb_q.size() > 0) begin
      step(8'h00, 8'h00, 1'b0, got, obs, exp);
      if (got) begin
        n_tests++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL %s_drain: P=%0d expected %0d", name, obs, exp);
        end
      end
      guard++;
      if (guard > 8) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_timeout: %0d results never appeared", name, sb_q.size());
        sb_q.delete();
      end
    end
  endtask

  task automatic test_directed();
    logic [7:0] av[] = '{8'd10, 8'd100, 8'd120, 8'd50, 8'd80, 8'd40};
    logic [7:0] bv[] = '{8'd10, 8'd200, 8'd100, 8'd200, 8'd20, 8'd60};
    run_list("directed", av, bv);
  endtask

  task automatic test_corners();
    logic [7:0] av[] = '{8'd0,   8'd255, 8'd1, 8'd255, 8'd128};
    logic [7:0] bv[] = '{8'd255, 8'd0,   8'd1, 8'd255, 8'd2};
    run_list("corner", av, bv);
  endtask

  task automatic test_back_to_back();
    logic [7:0] av[] = '{8'd255, 8'd1, 8'd0};
    logic [7:0] bv[] = '{8'd255, 8'd1, 8'd0};
    run_list("back_to_back", av, bv);
  endtask

  task automatic test_reset_midstream();
    bit got;
    logic [15:0] obs, exp;
    logic [7:0] av[] = '{8'd200};
    logic [7:0] bv[] = '{8'd3};
    step(8'd37, 8'd91, 1'b1, got, obs, exp);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (P !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_midstream_async: P=%0h expected 0", P);
    end
    sb_q.delete();
    #2 rst_n = 1'b1;
    run_list("reset_midstream_after", av, bv);
  endtask

  task automatic test_random();
    logic [7:0] av[];
    logic [7:0] bv[];
    av = new[10000];
    bv = new[10000];
    for (int k = 0; k < 10000; k++) begin
      av[k] = 8'($urandom_range(0, 255));
      bv[k] = 8'($urandom_range(0, 255));
    end
    run_list("random", av, bv);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_corners();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
